// File: rtl/calc_seq_controller_if.sv
// Operand/result stream bundle for calc_seq_controller: frame control, operand byte
// stream in, result stream out. The controller uses the slave modport.
interface calc_seq_controller_if;
    logic       start;
    logic [7:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/calc_seq_controller.sv
// Frame sequencer: reads len (a,b) operand pairs, evaluates the even/odd function,
// queues results in an output FIFO. Optional trailing checksum word: CALC_CHECKSUM_EN.
module calc_seq_controller #(
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    calc_seq_controller_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, CALC, FIN, DRAIN} state_t;

    function automatic logic [7:0] calc_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = {b[6:0], 1'b0} + a;
        return a[0] ? (s - 8'd1) : (s + 8'd3);
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic       done_q, done_d;
`ifdef CALC_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
`endif

    logic [8:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic       push, pop, full;
    logic [8:0] push_word;
    logic [7:0] result;

    assign result = calc_fn(a_q, b_q);
    assign pop    = (count_q != '0) && bus.out_ready;
    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        done_d    = 1'b0;
        push      = 1'b0;
        push_word = '0;
`ifdef CALC_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.len;
`ifdef CALC_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = (bus.len != 8'd0) ? GET_A : FIN;
                end
            end
            GET_A: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = GET_B;
                end
            end
            GET_B: begin
                if (bus.in_valid) begin
                    b_d     = bus.in_data;
                    state_d = CALC;
                end
            end
            CALC: begin
                // A pop in this cycle frees a slot even when the FIFO is full
                if (!full || pop) begin
                    push    = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
`ifdef CALC_CHECKSUM_EN
                    push_word = {1'b0, result};
                    csum_d    = csum_q + result;
`else
                    push_word = {(cnt_q == 8'd1), result};
`endif
                    state_d = (cnt_q == 8'd1) ? FIN : GET_A;
                end
            end
            FIN: begin
`ifdef CALC_CHECKSUM_EN
                if (!full || pop) begin
                    push      = 1'b1;
                    push_word = {1'b1, csum_q};
                    state_d   = DRAIN;
                end
`else
                state_d = DRAIN;
`endif
            end
            DRAIN: begin
                // Finish as soon as the FIFO will be empty after this cycle
                if ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
`ifdef CALC_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
`ifdef CALC_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = (state_q == GET_A) || (state_q == GET_B);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = (count_q != '0);
    assign {bus.out_last, bus.out_data} = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_calc_seq_controller.sv
// Directed bench for calc_seq_controller; expectations follow CALC_CHECKSUM_EN when defined.
module tb_calc_seq_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   done_cnt;
    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];

    calc_seq_controller_if bus();

    calc_seq_controller #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record output handshakes and done pulses mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_last, bus.out_data});
            if (bus.done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic send_byte(input logic [7:0] x);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("in_handshake_timeout", 32'(n < 100), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] b);
        send_byte(a);
        send_byte(b);
    endtask

    task automatic start_frame(input logic [7:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!bus.done && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, 32'(n < 300), 32'd1);
        tick();
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic compare_words(input string tag);
        chk({tag, "_word_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_word%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},      32'(bus.busy),      32'd0);
        chk({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        done_cnt     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.len      = 8'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk_reset_outputs("por");
        rst_n = 1'b1;
        tick();

        // Basic two-pair frame
        start_frame(8'd2);
        chk("basic_busy_rise", 32'(bus.busy), 32'd1);
        chk("basic_in_ready_rise", 32'(bus.in_ready), 32'd1);
        send_pair(8'h04, 8'h05);
        send_pair(8'h03, 8'h05);
        wait_done("basic");
`ifdef CALC_CHECKSUM_EN
        exp_q = '{9'h011, 9'h00C, 9'h11D};
`else
        exp_q = '{9'h011, 9'h10C};
`endif
        compare_words("basic");

        // Wrap-around with a start pulse mid-frame that must be ignored
        start_frame(8'd2);
        send_pair(8'hFF, 8'h80);
        start_frame(8'd5);
        send_pair(8'h00, 8'hFF);
        wait_done("wrap");
`ifdef CALC_CHECKSUM_EN
        exp_q = '{9'h0FE, 9'h001, 9'h1FF};
`else
        exp_q = '{9'h0FE, 9'h101};
`endif
        compare_words("wrap");

        // Reset mid-frame after the a byte of pair 2, with a word parked in the FIFO
        bus.out_ready = 1'b0;
        start_frame(8'd3);
        send_pair(8'h04, 8'h05);
        send_byte(8'h03);
        tick();
        chk("midrst_word_parked", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        got_q.delete();
        done_cnt = 0;
        bus.out_ready = 1'b1;
        tick();
        start_frame(8'd1);
        send_pair(8'h04, 8'h05);
        wait_done("postrst");
`ifdef CALC_CHECKSUM_EN
        exp_q = '{9'h011, 9'h111};
`else
        exp_q = '{9'h111};
`endif
        compare_words("postrst");

        // Backpressure: four results fill the FIFO, the fifth stalls in CALC
        bus.out_ready = 1'b0;
        start_frame(8'd6);
        send_pair(8'h01, 8'h02);
        send_pair(8'h02, 8'h03);
        send_pair(8'h03, 8'h04);
        send_pair(8'h04, 8'h05);
        send_pair(8'h05, 8'h06);
        for (int i = 0; i < 8; i++) tick();
        chk("bp_in_ready_stalled", 32'(bus.in_ready), 32'd0);
        chk("bp_busy", 32'(bus.busy), 32'd1);
        chk("bp_head_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_head_data", 32'(bus.out_data), 32'h04);
        chk("bp_no_words_out", 32'(got_q.size()), 32'd0);
        // Pop and push on the same edge while full: CALC leaves at once
        bus.out_ready = 1'b1;
        tick();
        chk("bp_bypass_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_bypass_head_data", 32'(bus.out_data), 32'h0B);
        send_pair(8'h06, 8'h07);
        wait_done("bp");
`ifdef CALC_CHECKSUM_EN
        exp_q = '{9'h004, 9'h00B, 9'h00A, 9'h011, 9'h010, 9'h017, 9'h151};
`else
        exp_q = '{9'h004, 9'h00B, 9'h00A, 9'h011, 9'h010, 9'h117};
`endif
        compare_words("bp");

        // Empty frame: done three cycles after start
        start_frame(8'd0);
        chk("len0_t1_busy", 32'(bus.busy), 32'd1);
        chk("len0_t1_in_ready", 32'(bus.in_ready), 32'd0);
        chk("len0_t1_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("len0_t2_done", 32'(bus.done), 32'd0);
`ifdef CALC_CHECKSUM_EN
        chk("len0_t2_out_valid", 32'(bus.out_valid), 32'd1);
        chk("len0_t2_word", 32'({bus.out_last, bus.out_data}), 32'h100);
`else
        chk("len0_t2_out_valid", 32'(bus.out_valid), 32'd0);
`endif
        tick();
        chk("len0_t3_done", 32'(bus.done), 32'd1);
        chk("len0_t3_busy", 32'(bus.busy), 32'd0);
        tick();
        chk("len0_done_once", 32'(done_cnt), 32'd1);
`ifdef CALC_CHECKSUM_EN
        exp_q = '{9'h100};
`endif
        compare_words("len0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_seq_controller.md
# calc_seq_controller

Frame sequencer for the sequence-calculator datapath. It accepts a frame of `len` operand pairs on a valid/ready byte stream and evaluates the even/odd compute function on each pair. Results go into a small output FIFO, which presents them on a valid/ready result stream with a last-word flag. It sits between the operand source and the result sink, serialising access to the single 8-bit compute function.

## Interface

- `FIFO_DEPTH`, default 4: output FIFO entries. Must be a power of two, 2 or more.
- `clk`, input, 1: single clock. All logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: frame start. Sampled only in IDLE and ignored otherwise.
- `len`, input, 8: number of operand pairs. Latched when `start` is accepted.
- `in_valid`, input, 1: operand byte valid.
- `in_data`, input, 8: operand byte. Bytes alternate: `a` (in0) first, then `b` (in1).
- `in_ready`, output, 1: operand byte accepted when `in_valid && in_ready`.
- `out_valid`, output, 1: FIFO head valid.
- `out_data`, output, 8: FIFO head data.
- `out_last`, output, 1: FIFO head is the final word of the frame.
- `out_ready`, input, 1: sink accepts the head when `out_valid && out_ready`.
- `busy`, output, 1: frame in progress.
- `done`, output, 1: one-cycle pulse at frame completion.

## Operation

- Compute function, all arithmetic mod 256:
  - `r = ((b<<1)[7:0] + a) + 3` when `a[0]==0`.
  - `r = ((b<<1)[7:0] + a) - 1` when `a[0]==1`.
- FSM states: IDLE, GET_A, GET_B, CALC, FIN, DRAIN.
- IDLE:
  - `start` latches `len` into the remaining-pair counter and clears the checksum.
  - Goes to GET_A if `len!=0`, otherwise to FIN.
- GET_A: `in_ready=1`. On handshake, register `a` and go to GET_B.
- GET_B: `in_ready=1`. On handshake, register `b` and go to CALC.
- CALC:
  - Push `r` into the FIFO when a slot is free, or when a pop happens in the same cycle.
  - On push: decrement the counter and add `r` to the checksum.
  - If the counter reaches 0, go to FIN; otherwise go to GET_A.
  - If no slot is free, stall in CALC. `in_ready` stays 0 while stalled.
- FIN: behaviour depends on `CALC_CHECKSUM_EN` (see Configuration). Then go to DRAIN.
- DRAIN: wait until the FIFO is empty, pulse `done`, return to IDLE.
- FIFO ordering and flags:
  - Strict FIFO order.
  - Each entry carries {last, data}.
  - Pop on output handshake.
  - Push and pop in the same cycle are both performed, whether the FIFO is full or empty.
- `busy=1` in every state except IDLE.
- Reset asserted at any time, including mid-frame:
  - FSM returns to IDLE.
  - FIFO is emptied.
  - Counter, checksum and operand registers are cleared.
  - Partial frame is discarded.

## Timing

- Reset values: `in_ready=0`, `out_valid=0`, `out_data=0x00`, `out_last=0`, `busy=0`, `done=0`.
- All outputs are driven from registers, except the FIFO-full bypass term in the CALC push condition.
- `start` high in IDLE at cycle t gives `busy=1` at t+1. When `len!=0`, `in_ready=1` also rises at t+1.
- `b` handshake at cycle t:
  - CALC at t+1.
  - With a free slot, the push happens at the t+1 edge and `out_valid=1` with the result at t+2.
- Minimum of 3 cycles per pair: GET_A, GET_B, CALC.
- `done` pulses in the cycle after the last word's output handshake. `busy` falls in that same cycle.
- `len=0` with the macro undefined: no words are emitted. `done` pulses at t+3, passing through FIN and DRAIN.
- Backpressure: while `out_ready=0` and the FIFO is full, CALC stalls indefinitely with no data loss.

## Configuration

- `CALC_CHECKSUM_EN` defined:
  - FIN pushes one extra word: the 8-bit checksum (sum mod 256 of all frame results), with `last=1`.
  - FIN waits for a free slot before pushing.
  - All result words carry `last=0`.
  - `len=0` emits the single word 0x00 with `last=1`.
- `CALC_CHECKSUM_EN` undefined:
  - No checksum logic is built.
  - The final result word carries `last=1`.
  - FIN is a single pass-through cycle.

## Test plan

- Reset mid-frame, after the `a` handshake of pair 2 of a `len=3` frame:
  - All outputs take their reset values.
  - The next `start` with `len=1` and pair (0x04,0x05) outputs 0x11.
- `len=2`, pairs (0x04,0x05), (0x03,0x05), `out_ready=1`:
  - Outputs 0x11 then 0x0C.
  - Macro undefined: `last` is set on 0x0C.
  - Macro defined: a third word 0x1D is emitted with `last=1`.
  - `done` pulses once.
- Wrap-around, pairs (0xFF,0x80) then (0x00,0xFF):
  - Outputs 0xFE then 0x01.
  - Macro defined: checksum 0xFF.
- Backpressure, `FIFO_DEPTH=4`, `len=6`, `out_ready=0`:
  - Exactly 4 results are buffered, the FSM stalls in CALC, and `in_ready` stays 0.
  - Raising `out_ready` delivers all 6 results (7 words with the macro) in order, with no gaps beyond the 3-cycle pair rate.
- `start` pulsed while busy: ignored, frame unaffected.
- Full FIFO plus simultaneous pop: push and pop in the same cycle, occupancy held at 4.
- `len=0`:
  - Macro undefined: no `out_valid`, `done` at t+3.
  - Macro defined: one word 0x00 with `last=1`, then `done`.
